// File: rtl/weights_loader.sv
// weights_loader
// Sequencing stage in front of the weights RAM. A burst of weight words
// arriving on the AXI-Stream slave is written to consecutive RAM addresses.
// The stored block is then replayed cfg_repeats times (0 means once) on the
// AXI-Stream master. Master backpressure stalls the RAM read pipeline through
// ram_ena, so no skid buffer is needed.
//
// Ports
//   clk, rstn        single clock, asynchronous active-low reset
//   cfg_repeats      replay count, sampled on the first accepted fill beat
//   s_axis_*         slave stream (data/valid/ready/last), fill side
//   m_axis_*         master stream (data/valid/ready/last), replay side
//   ram_ena/wea      RAM enable and write enable
//   ram_addra        RAM address
//   ram_dina         RAM write data
//   ram_douta        RAM read data, passed straight to m_axis_data
//   err_overflow     sticky: a block filled the RAM without a last beat
module weights_loader #(
  parameter int DEPTH    = 256,
  parameter int WIDTH    = 64,
  parameter int LATENCY  = 2,
  parameter int REP_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [REP_BITS-1:0]      cfg_repeats,
  input  logic [WIDTH-1:0]         s_axis_data,
  input  logic                     s_axis_valid,
  output logic                     s_axis_ready,
  input  logic                     s_axis_last,
  output logic [WIDTH-1:0]         m_axis_data,
  output logic                     m_axis_valid,
  input  logic                     m_axis_ready,
  output logic                     m_axis_last,
  output logic                     ram_ena,
  output logic                     ram_wea,
  output logic [$clog2(DEPTH)-1:0] ram_addra,
  output logic [WIDTH-1:0]         ram_dina,
  input  logic [WIDTH-1:0]         ram_douta,
  output logic                     err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]       CNT_ONE = CW'(1);
  localparam logic [CW-1:0]       CNT_TOP = CW'(DEPTH - 1);
  localparam logic [REP_BITS-1:0] REP_ONE = REP_BITS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       wcnt_r;
  logic [CW-1:0]       nwords_r;
  logic [CW-1:0]       raddr_r;
  logic [REP_BITS-1:0] rep_r;
  logic [REP_BITS-1:0] repeats_r;
  logic [LATENCY-1:0]  vpipe_r;
  logic [LATENCY-1:0]  lpipe_r;
  logic                err_overflow_r;

  logic                wbeat_s;
  logic [CW-1:0]       waddr_s;
  logic                term_s;
  logic                ovf_s;
  logic                adv_s;
  logic                issue_s;
  logic                rd_wrap_s;
  logic                rd_last_s;
  logic [LATENCY-1:0]  vnext_s;
  logic [LATENCY-1:0]  lnext_s;

  assign s_axis_ready = (state_r != DRAIN);
  assign wbeat_s      = s_axis_valid & s_axis_ready;
  // The first beat of a block always lands at address 0, whatever wcnt holds.
  assign waddr_s      = (state_r == IDLE) ? {CW{1'b0}} : wcnt_r;
  assign term_s       = wbeat_s & (s_axis_last | (waddr_s == CNT_TOP));
  assign ovf_s        = wbeat_s & ~s_axis_last & (waddr_s == CNT_TOP);

  assign m_axis_valid = vpipe_r[LATENCY-1];
  assign m_axis_last  = m_axis_valid & lpipe_r[LATENCY-1];
  assign m_axis_data  = ram_douta;
  assign err_overflow = err_overflow_r;

  // The read pipe only moves when the output slot is free or being taken.
  assign adv_s     = ~m_axis_valid | m_axis_ready;
  assign issue_s   = adv_s & (state_r == DRAIN) & (rep_r != repeats_r);
  assign rd_wrap_s = (raddr_r == (nwords_r - CNT_ONE));
  assign rd_last_s = rd_wrap_s & (rep_r == (repeats_r - REP_ONE));

  generate
    if (LATENCY == 1) begin : g_pipe1
      assign vnext_s = issue_s;
      assign lnext_s = issue_s & rd_last_s;
    end else begin : g_pipen
      assign vnext_s = {vpipe_r[LATENCY-2:0], issue_s};
      assign lnext_s = {lpipe_r[LATENCY-2:0], issue_s & rd_last_s};
    end
  endgenerate

  // RAM port steering: write beats while filling, stalled reads while draining.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = {AW{1'b0}};
    ram_dina  = {WIDTH{1'b0}};
    case (state_r)
      IDLE, FILL: begin
        if (wbeat_s) begin
          ram_ena   = 1'b1;
          ram_wea   = 1'b1;
          ram_addra = waddr_s[AW-1:0];
          ram_dina  = s_axis_data;
        end else begin
          ram_ena   = 1'b0;
          ram_wea   = 1'b0;
        end
      end
      DRAIN: begin
        ram_ena = adv_s;
        if (issue_s) begin
          ram_addra = raddr_r[AW-1:0];
        end else begin
          ram_addra = {AW{1'b0}};
        end
      end
      default: begin
        ram_ena = 1'b0;
      end
    endcase
  end

  // Sequencer: fill counting, replay address/repeat counters and valid/last pipes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r        <= IDLE;
      wcnt_r         <= {CW{1'b0}};
      nwords_r       <= {CW{1'b0}};
      raddr_r        <= {CW{1'b0}};
      rep_r          <= {REP_BITS{1'b0}};
      repeats_r      <= {REP_BITS{1'b0}};
      vpipe_r        <= {LATENCY{1'b0}};
      lpipe_r        <= {LATENCY{1'b0}};
      err_overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, FILL: begin
          if (wbeat_s) begin
            wcnt_r <= waddr_s + CNT_ONE;
            if (state_r == IDLE) begin
              repeats_r <= (cfg_repeats == {REP_BITS{1'b0}}) ? REP_ONE : cfg_repeats;
            end
            if (term_s) begin
              nwords_r <= waddr_s + CNT_ONE;
              raddr_r  <= {CW{1'b0}};
              rep_r    <= {REP_BITS{1'b0}};
              state_r  <= DRAIN;
              if (ovf_s) begin
                err_overflow_r <= 1'b1;
              end
            end else begin
              state_r <= FILL;
            end
          end
        end
        DRAIN: begin
          if (adv_s) begin
            vpipe_r <= vnext_s;
            lpipe_r <= lnext_s;
          end
          if (issue_s) begin
            if (rd_wrap_s) begin
              raddr_r <= {CW{1'b0}};
              rep_r   <= rep_r + REP_ONE;
            end else begin
              raddr_r <= raddr_r + CNT_ONE;
            end
          end
          // The final beat is the last read issued, so the pipe is empty behind it.
          if (m_axis_valid & m_axis_ready & m_axis_last) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weights_loader.sv
`timescale 1ns/1ps
module tb_weights_loader;
  localparam int NI = 3;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  typedef logic [W-1:0] wq_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [15:0]   cfg_rep   [NI];
  logic [W-1:0]  s_data    [NI];
  logic          s_valid   [NI];
  logic          s_last    [NI];
  logic          m_ready   [NI];
  logic          s_ready   [NI];
  logic [W-1:0]  m_data    [NI];
  logic          m_valid   [NI];
  logic          m_last    [NI];
  logic          ram_ena   [NI];
  logic          ram_wea   [NI];
  logic [AW-1:0] ram_addra [NI];
  logic [W-1:0]  ram_dina  [NI];
  logic [W-1:0]  ram_douta [NI];
  logic          err       [NI];

  int errors = 0;
  int checks = 0;

  // Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 4.
  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [W-1:0] mem  [D];
      logic [W-1:0] pipe [LAT];

      weights_loader #(.DEPTH(D), .WIDTH(W), .LATENCY(LAT), .REP_BITS(16)) u_dut (
        .clk(clk), .rstn(rstn), .cfg_repeats(cfg_rep[g]),
        .s_axis_data(s_data[g]), .s_axis_valid(s_valid[g]), .s_axis_ready(s_ready[g]),
        .s_axis_last(s_last[g]),
        .m_axis_data(m_data[g]), .m_axis_valid(m_valid[g]), .m_axis_ready(m_ready[g]),
        .m_axis_last(m_last[g]),
        .ram_ena(ram_ena[g]), .ram_wea(ram_wea[g]), .ram_addra(ram_addra[g]),
        .ram_dina(ram_dina[g]), .ram_douta(ram_douta[g]), .err_overflow(err[g])
      );

      // RAM with LAT enabled-cycle read latency; the whole pipe holds when ena is low.
      always @(posedge clk) begin
        if (ram_ena[g]) begin
          if (ram_wea[g]) mem[ram_addra[g]] <= ram_dina[g];
          pipe[0] <= mem[ram_addra[g]];
          for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign ram_douta[g] = pipe[LAT-1];
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the block repeated max(reps,1) times.
  function automatic wq_t expand(input wq_t w, input int reps);
    wq_t q;
    int r = (reps == 0) ? 1 : reps;
    for (int i = 0; i < r; i++)
      foreach (w[j]) q.push_back(w[j]);
    return q;
  endfunction

  // Offer every word of 'words' one per cycle; count accepted beats.
  task automatic do_fill(input int k, input wq_t words, input int reps, input bit with_last,
                         output int accepted, output int first_rej);
    accepted  = 0;
    first_rej = -1;
    cfg_rep[k] = 16'(reps);
    for (int i = 0; i < words.size(); i++) begin
      s_valid[k] = 1'b1;
      s_data[k]  = words[i];
      s_last[k]  = with_last && (i == words.size() - 1);
      #1;
      if (s_ready[k] === 1'b1) begin
        checks++;
        if (ram_ena[k] !== 1'b1 || ram_wea[k] !== 1'b1 ||
            ram_addra[k] !== AW'(accepted) || ram_dina[k] !== words[i])
          begin
            errors++;
            $display("FAIL write_beat inst%0d beat%0d: ena=%b wea=%b addr=%0d din=%h, want 1 1 %0d %h",
                     k, i, ram_ena[k], ram_wea[k], ram_addra[k], ram_dina[k], accepted, words[i]);
          end
        accepted++;
      end else begin
        if (first_rej < 0) first_rej = i;
        checks++;
        if (ram_wea[k] !== 1'b0) begin
          errors++;
          $display("FAIL no_write_in_drain inst%0d beat%0d: wea=%b want 0", k, i, ram_wea[k]);
        end
      end
      tick();
      // Replay count must come from the first beat only.
      cfg_rep[k] = 16'($urandom_range(5, 9));
    end
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  // Collect replayed beats and compare with the expected stream.
  task automatic collect(input int k, input wq_t exp_q, input bit rand_ready, input int start_c,
                         input bit check_lat, input int abort_after, input string name);
    int n = exp_q.size();
    int target = (abort_after >= 0) ? abort_after : n;
    int got = 0;
    int c = start_c;
    int first = -1;
    int budget = 60 + n * 8;
    bit prev_stall = 1'b0;
    logic [W-1:0] pd;
    logic pl;
    logic el;
    while (got < target && c < start_c + budget) begin
      m_ready[k] = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (prev_stall) begin
        checks++;
        if (m_valid[k] !== 1'b1 || m_data[k] !== pd || m_last[k] !== pl) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h last=%b, want 1 %h %b",
                   name, m_valid[k], m_data[k], m_last[k], pd, pl);
        end
      end
      if (m_valid[k] === 1'b1 && first < 0) first = c;
      if (m_valid[k] === 1'b1 && m_ready[k] === 1'b1) begin
        el = (got == n - 1);
        checks++;
        if (m_data[k] !== exp_q[got] || m_last[k] !== el) begin
          errors++;
          $display("FAIL %s beat%0d: data=%h last=%b, want %h %b",
                   name, got, m_data[k], m_last[k], exp_q[got], el);
        end
        got++;
      end
      prev_stall = (m_valid[k] === 1'b1) && (m_ready[k] !== 1'b1);
      pd = m_data[k];
      pl = m_last[k];
      tick();
      c++;
    end
    checks++;
    if (got != target) begin
      errors++;
      $display("FAIL %s beat_count: got %0d beats, want %0d (cycle budget)", name, got, target);
    end
    if (check_lat) begin
      checks++;
      if (first != lat_of(k)) begin
        errors++;
        $display("FAIL %s first_valid: cycle %0d, want %0d", name, first, lat_of(k));
      end
    end
    if (abort_after < 0) begin
      m_ready[k] = 1'b1;
      #1;
      checks++;
      if (m_valid[k] !== 1'b0 || s_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s return_to_fill: valid=%b s_ready=%b, want 0 1", name, m_valid[k], s_ready[k]);
      end
      tick();
    end
  endtask

  task automatic run_block(input int k, input wq_t w, input int reps, input bit rand_ready,
                           input string name);
    int acc, rej;
    m_ready[k] = 1'b1;
    do_fill(k, w, reps, 1'b1, acc, rej);
    checks++;
    if (acc != w.size()) begin
      errors++;
      $display("FAIL %s accepted: %0d, want %0d", name, acc, w.size());
    end
    collect(k, expand(w, reps), rand_ready, 0, 1'b1, -1, name);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (s_ready[k] !== 1'b1 || m_valid[k] !== 1'b0 || m_last[k] !== 1'b0 ||
          ram_ena[k] !== 1'b0 || ram_wea[k] !== 1'b0 || ram_addra[k] !== 3'd0 || err[k] !== 1'b0)
        begin
          errors++;
          $display("FAIL reset_values inst%0d: rdy=%b v=%b l=%b ena=%b wea=%b addr=%0d err=%b, want 1 0 0 0 0 0 0",
                   k, s_ready[k], m_valid[k], m_last[k], ram_ena[k], ram_wea[k], ram_addra[k], err[k]);
        end
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wq_t w = '{8'h00, 8'h01, 8'h02, 8'h03};
    run_block(0, w, 2, 1'b0, "basic_lat2");
  endtask

  task automatic test_latency();
    wq_t w = '{8'h00, 8'h01, 8'h02, 8'h03};
    run_block(1, w, 2, 1'b0, "basic_lat1");
    run_block(2, w, 2, 1'b0, "basic_lat4");
  endtask

  task automatic test_backpressure();
    wq_t w = '{8'h00, 8'h01, 8'h02, 8'h03};
    run_block(0, w, 2, 1'b1, "backpressure_lat2");
    run_block(2, w, 3, 1'b1, "backpressure_lat4");
  endtask

  task automatic test_single_beat();
    wq_t w = '{8'hA5};
    run_block(0, w, 0, 1'b0, "single_beat_rep0");
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      wq_t w;
      int len = $urandom_range(1, D);
      for (int i = 0; i < len; i++) w.push_back(W'($urandom));
      run_block(t % NI, w, $urandom_range(0, 3), 1'b1, "random_block");
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (err[k] !== 1'b0) begin
        errors++;
        $display("FAIL no_overflow inst%0d: err=%b want 0", k, err[k]);
      end
    end
  endtask

  task automatic test_overflow();
    wq_t w;
    int acc, rej;
    for (int i = 0; i < 10; i++) w.push_back(W'($urandom));
    m_ready[0] = 1'b1;
    do_fill(0, w, 1, 1'b0, acc, rej);
    checks++;
    if (acc != D || rej != D) begin
      errors++;
      $display("FAIL overflow_accept: accepted=%0d first_reject=%0d, want %0d %0d", acc, rej, D, D);
    end
    checks++;
    if (err[0] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: err=%b want 1", err[0]);
    end
    w = w[0:D-1];
    // Two drain cycles already elapsed while the rejected beats were offered.
    collect(0, expand(w, 1), 1'b0, 2, 1'b1, -1, "overflow_replay");
    checks++;
    if (err[0] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: err=%b want 1", err[0]);
    end
  endtask

  task automatic test_reset_mid_drain();
    wq_t w = '{8'h10, 8'h11, 8'h12, 8'h13};
    wq_t w2;
    int acc, rej;
    m_ready[0] = 1'b1;
    do_fill(0, w, 2, 1'b1, acc, rej);
    collect(0, expand(w, 2), 1'b0, 0, 1'b0, 3, "pre_reset");
    rstn = 1'b0;
    #1;
    checks++;
    if (m_valid[0] !== 1'b0 || m_last[0] !== 1'b0 || s_ready[0] !== 1'b1 ||
        err[0] !== 1'b0 || ram_ena[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain_reset: v=%b l=%b rdy=%b err=%b ena=%b, want 0 0 1 0 0",
               m_valid[0], m_last[0], s_ready[0], err[0], ram_ena[0]);
    end
    tick();
    rstn = 1'b1;
    tick();
    w2.push_back(W'($urandom));
    w2.push_back(W'($urandom));
    run_block(0, w2, 1, 1'b0, "after_reset_fill");
    run_block(0, w2, 3, 1'b1, "after_reset_rep3");
  endtask

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < NI; k++) begin
      cfg_rep[k] = 16'd0;
      s_data[k]  = '0;
      s_valid[k] = 1'b0;
      s_last[k]  = 1'b0;
      m_ready[k] = 1'b1;
    end
    #2;
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_single_beat();
    test_random();
    test_overflow();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
